// File: rtl/ebpf_mul_wb_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ebpf_mul_wb_stage_if
// Brief   : Push side (multiplier product) and pop side (writeback) bundle.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
interface ebpf_mul_wb_stage_if #(
  parameter int REG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       in_product;
  logic [REG_W-1:0]   in_dst;
  logic               in_alu32;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_data;
  logic [REG_W-1:0]   out_dst;
  logic               out_ovf;

  // slave: the result stage itself; master: multiplier + writeback side
  modport slave (
    input  in_valid, in_product, in_dst, in_alu32, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_ovf
  );

  modport master (
    output in_valid, in_product, in_dst, in_alu32, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_ovf
  );
endinterface
`default_nettype wire

// File: rtl/ebpf_mul_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : ebpf_mul_wb_stage
// Brief   : Two-entry result buffer after Mult_64bit; narrows the 128-bit
//           product to ALU64/ALU32 width. MUL_OVF_FLAG_EN adds overflow flag.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module ebpf_mul_wb_stage #(
  parameter int DEPTH = 2,
  parameter int REG_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  ebpf_mul_wb_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_rd_ptr;
  logic               r_wr_ptr;
  logic [63:0]        r_data [DEPTH];
  logic [REG_W-1:0]   r_dst  [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic [63:0]        w_narrow;

  assign bus.in_ready  = (r_state != ST_FULL);
  assign bus.out_valid = (r_state != ST_EMPTY);

  assign w_push = bus.in_valid  && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  // Narrowing happens once at push so the output path is a plain mux.
  assign w_narrow = bus.in_alu32 ? {32'h0, bus.in_product[31:0]}
                                 : bus.in_product[63:0];

  assign bus.out_data = r_data[r_rd_ptr];
  assign bus.out_dst  = r_dst[r_rd_ptr];

`ifdef MUL_OVF_FLAG_EN
  logic               r_ovf [DEPTH];
  logic               w_ovf;
  logic [64:0]        w_hi64;
  logic [96:0]        w_hi32;

  // Product fits when every bit from the destination sign bit upward agrees.
  assign w_hi64 = bus.in_product[127:63];
  assign w_hi32 = bus.in_product[127:31];
  assign w_ovf  = bus.in_alu32 ? !((&w_hi32) || !(|w_hi32))
                               : !((&w_hi64) || !(|w_hi64));

  assign bus.out_ovf = r_ovf[r_rd_ptr];
`else
  logic               w_unused_prod_hi;

  assign w_unused_prod_hi = ^bus.in_product[127:64];
  assign bus.out_ovf      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_dst[i]  <= '0;
`ifdef MUL_OVF_FLAG_EN
        r_ovf[i]  <= 1'b0;
`endif
      end
    end else begin
      if (w_push) begin
        r_data[r_wr_ptr] <= w_narrow;
        r_dst[r_wr_ptr]  <= bus.in_dst;
`ifdef MUL_OVF_FLAG_EN
        r_ovf[r_wr_ptr]  <= w_ovf;
`endif
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_state <= ST_ONE;
        end
        ST_ONE: begin
          if (w_push && !w_pop)      r_state <= ST_FULL;
          else if (w_pop && !w_push) r_state <= ST_EMPTY;
        end
        ST_FULL: begin
          if (w_pop) r_state <= ST_ONE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ebpf_mul_wb_stage.sv
`default_nettype none
// tb_ebpf_mul_wb_stage: randomized + directed stimulus, queue scoreboard
// against an arithmetic range model of narrowing and overflow.
module tb_ebpf_mul_wb_stage;

  typedef struct packed {
    logic        ovf;
    logic [3:0]  dst;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t scb[$];

  ebpf_mul_wb_stage_if #(.REG_W(4)) bus ();

  ebpf_mul_wb_stage #(.DEPTH(2), .REG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result is the product modulo 2^64 (or 2^32, zero-extended); overflow is
  // the signed product lying outside the destination's signed range.
  function automatic exp_t model(input logic [127:0] p, input logic a32, input logic [3:0] d);
    exp_t                 e;
    logic signed [127:0]  sp;
    logic signed [127:0]  lo;
    logic signed [127:0]  hi;
    sp = p;
    if (a32) begin
      hi = 128'sd2147483647;
      lo = -128'sd2147483648;
      e.data = {32'h0, p[31:0]};
    end else begin
      hi = 128'sd9223372036854775807;
      lo = -128'sd9223372036854775808;
      e.data = p[63:0];
    end
    e.dst = d;
`ifdef MUL_OVF_FLAG_EN
    e.ovf = (sp > hi) || (sp < lo);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic a32, input logic [3:0] d);
    int n;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_alu32   = a32;
    bus.in_dst     = d;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end else begin
      scb.push_back(model(p, a32, d));
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd_prod();
    logic signed [63:0]  a;
    logic signed [63:0]  b;
    logic signed [127:0] p;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: begin a = a >>> 40; b = b >>> 40; end
      1: begin a = a >>> 50; b = b >>> 52; end
      2: begin a = a >>> 20; b = b >>> 30; end
      default: ;
    endcase
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    return p;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (scb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", 128'(scb.size()), 128'd0);
  endtask

  // Head must match the oldest expectation on every valid cycle, which also
  // covers holding stable under back-pressure.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid) begin
        if (scb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual=%h required=no_output", bus.out_data);
        end else begin
          e = scb[0];
          chk("head", {bus.out_ovf, bus.out_dst, bus.out_data}, e);
          if (bus.out_ready) void'(scb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] p;
    total = 0;
    bad   = 0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_dst     = '0;
    bus.in_alu32   = 1'b0;
    bus.out_ready  = 1'b0;
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
    chk("rst_out_data",  128'(bus.out_data),  128'd0);
    chk("rst_out_dst",   128'(bus.out_dst),   128'd0);
    chk("rst_out_ovf",   128'(bus.out_ovf),   128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed products with writeback always ready
    bus.out_ready = 1'b1;
    send(128'd24, 1'b0, 4'd3);
    chk("latency_valid", 128'(bus.out_valid), 128'd1);
    p = 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001;
    send(p, 1'b0, 4'd5);
    p = 128'h0000_0000_0000_0000_0000_0001_8000_0000;
    send(p, 1'b1, 4'd1);
    p = '1;
    send(p, 1'b1, 4'd10);
    drain();

    // A, B fill the stage; C must wait until A pops
    bus.out_ready = 1'b0;
    send(128'hA, 1'b0, 4'd1);
    send(128'hB, 1'b0, 4'd2);
    chk("full_in_ready", 128'(bus.in_ready), 128'd0);
    bus.in_valid   = 1'b1;
    bus.in_product = 128'hC;
    bus.in_alu32   = 1'b0;
    bus.in_dst     = 4'd3;
    bus.out_ready  = 1'b1;
    tick();
    chk("ready_after_pop", 128'(bus.in_ready), 128'd1);
    scb.push_back(model(128'hC, 1'b0, 4'd3));
    tick();
    bus.in_valid = 1'b0;
    drain();

    // Steady streaming: one result per cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(rnd_prod(), 1'($urandom_range(0, 1)), 4'(i));
      chk("stream_valid", 128'(bus.out_valid), 128'd1);
    end
    tick();
    chk("stream_end_idle", 128'(bus.out_valid), 128'd0);

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_valid   = ($urandom_range(0, 2) != 0);
      bus.in_product = rnd_prod();
      bus.in_alu32   = 1'($urandom_range(0, 1));
      bus.in_dst     = 4'($urandom_range(0, 10));
      if (bus.in_valid && bus.in_ready)
        scb.push_back(model(bus.in_product, bus.in_alu32, bus.in_dst));
      tick();
    end
    drain();

    // Asynchronous reset with two entries buffered
    bus.out_ready = 1'b0;
    send(128'h11, 1'b0, 4'd4);
    send(128'h22, 1'b0, 4'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_in_ready",  128'(bus.in_ready),  128'd1);
    scb.delete();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(128'h33, 1'b1, 4'd7);
    tick();
    chk("post_rst_single", 128'(bus.out_valid), 128'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
